// File: rtl/neuron_accumulator_pkg.sv
// Shared types and sizing helpers for the neuron accumulator and its saturation stage.
package neuron_acc_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } acc_state_e;

  // Headroom bits beyond data width + log2(beats) so the accumulator and bias add never wrap.
  localparam int unsigned ACC_GUARD_BITS = 2;

  function automatic int unsigned beat_count_width(input int unsigned vector_len);
    return unsigned'($clog2(vector_len + 1));
  endfunction

  function automatic int unsigned min_acc_width(input int unsigned data_width,
                                                input int unsigned vector_len);
    return data_width + unsigned'($clog2(vector_len)) + ACC_GUARD_BITS;
  endfunction

  // Number of top sum bits that must all agree for the value to fit the output width.
  function automatic int unsigned sat_check_bits(input int unsigned acc_width,
                                                 input int unsigned out_width);
    return acc_width - out_width + 1;
  endfunction

endpackage

// File: rtl/neuron_accumulator_saturate.sv
// Combinational clamp of an accumulator-width sum to the signed output width.
// Optional ReLU stage enabled by NEURON_ACCUMULATOR_RELU_EN.
module acc_saturate
  import neuron_acc_pkg::*;
#(
  parameter int unsigned ACC_WIDTH = 48,
  parameter int unsigned OUT_WIDTH = 32
) (
  input  logic signed [ACC_WIDTH-1:0] sum,
  output logic signed [OUT_WIDTH-1:0] value_c,
  output logic                        sat_c
);

  localparam int unsigned CHECK_BITS = sat_check_bits(ACC_WIDTH, OUT_WIDTH);
  localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  logic [CHECK_BITS-1:0] top_bits;
  logic                  fits;

  assign top_bits = sum[ACC_WIDTH-1:OUT_WIDTH-1];
  assign fits     = (&top_bits) | (~|top_bits);

  always_comb begin
    value_c = sum[OUT_WIDTH-1:0];
    sat_c   = 1'b0;
    if (!fits) begin
      sat_c   = 1'b1;
      value_c = sum[ACC_WIDTH-1] ? OUT_MIN : OUT_MAX;
    end
`ifdef NEURON_ACCUMULATOR_RELU_EN
    // Negative results (clamped or not) become zero and are not reported as saturated.
    if (value_c[OUT_WIDTH-1]) begin
      value_c = '0;
      sat_c   = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/neuron_accumulator.sv
// Sums VECTOR_LEN signed product beats plus a bias, saturates, and holds one result per vector.
// Optional ReLU on the result via NEURON_ACCUMULATOR_RELU_EN (see acc_saturate).
module neuron_accumulator
  import neuron_acc_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ACC_WIDTH  = 48,
  parameter  int unsigned VECTOR_LEN = 16,
  parameter  int unsigned OUT_WIDTH  = 32,
  localparam int unsigned BC_WIDTH   = beat_count_width(VECTOR_LEN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] bias,
  output logic                         out_valid,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         out_sat,
  input  logic                         out_ready,
  output logic [BC_WIDTH-1:0]          beat_count
);

  if (ACC_WIDTH < min_acc_width(DATA_WIDTH, VECTOR_LEN)) begin : g_bad_acc_width
    $fatal(1, "neuron_accumulator: ACC_WIDTH too small for DATA_WIDTH/VECTOR_LEN");
  end
  if (VECTOR_LEN < 1) begin : g_bad_vector_len
    $fatal(1, "neuron_accumulator: VECTOR_LEN must be at least 1");
  end
  if (OUT_WIDTH > ACC_WIDTH) begin : g_bad_out_width
    $fatal(1, "neuron_accumulator: OUT_WIDTH must not exceed ACC_WIDTH");
  end

  localparam logic [BC_WIDTH-1:0] LAST_BEAT = BC_WIDTH'(VECTOR_LEN - 1);

  acc_state_e                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [BC_WIDTH-1:0]         count_d;
  logic                        in_ready_d;
  logic                        out_valid_d;
  logic signed [OUT_WIDTH-1:0] out_data_d;
  logic                        out_sat_d;

  logic signed [ACC_WIDTH-1:0] in_sext;
  logic signed [ACC_WIDTH-1:0] bias_sext;
  logic signed [ACC_WIDTH-1:0] final_sum;
  logic signed [OUT_WIDTH-1:0] sat_value_c;
  logic                        sat_flag_c;

  assign in_sext   = {{(ACC_WIDTH-DATA_WIDTH){in_data[DATA_WIDTH-1]}}, in_data};
  assign bias_sext = {{(ACC_WIDTH-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias};
  assign final_sum = acc_q + in_sext + bias_sext;

  acc_saturate #(
    .ACC_WIDTH (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_saturate (
    .sum     (final_sum),
    .value_c (sat_value_c),
    .sat_c   (sat_flag_c)
  );

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = beat_count;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    unique case (state_q)
      ACCUM: begin
        if (in_valid && in_ready) begin
          if (beat_count == LAST_BEAT) begin
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b1;
            out_data_d  = sat_value_c;
            out_sat_d   = sat_flag_c;
            state_d     = DRAIN;
          end else begin
            acc_d   = acc_q + in_sext;
            count_d = beat_count + BC_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      beat_count <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sat    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      beat_count <= count_d;
      in_ready   <= in_ready_d;
      out_valid  <= out_valid_d;
      out_data   <= out_data_d;
      out_sat    <= out_sat_d;
    end
  end

endmodule
